// File: rtl/retire_ctrl_if.sv
// Commit-stage bundle: ROB head window in, retirement strobes and map/freelist updates out.
// The ROB/rename side uses the master modport and retire_ctrl uses slave.
interface retire_ctrl_if #(
    parameter int N       = 4,
    parameter int ARW     = 5,
    parameter int PRW     = 6,
    parameter int ROB_IDX = 5,
    parameter int CNT_W   = 64
);
    localparam int PCW = $clog2(N + 1);

    logic [N-1:0]               head_valid;
    logic [N-1:0]               head_complete;
    logic [N-1:0]               head_has_dest;
    logic [N-1:0][ARW-1:0]      head_dest_ar;
    logic [N-1:0][PRW-1:0]      head_tnew;
    logic [N-1:0][PRW-1:0]      head_told;
    logic [N-1:0]               head_branch;
    logic [N-1:0]               head_pred_taken;
    logic [N-1:0]               head_taken;
    logic [N-1:0][31:0]         head_pred_target;
    logic [N-1:0][31:0]         head_target;
    logic [N-1:0][31:0]         head_npc;
    logic [N-1:0]               head_store;
    logic [N-1:0]               head_halt;
    logic [N-1:0][ROB_IDX-1:0]  head_rob_idx;
    logic                       sq_commit_ready;

    logic [PCW-1:0]             rob_pop_cnt;
    logic                       rob_flush;
    logic [ROB_IDX-1:0]         rob_flush_idx;
    logic                       BPRecoverEN;
    logic                       redirect_en;
    logic [31:0]                redirect_pc;
    logic [N-1:0]               Arch_Retire_EN;
    logic [N-1:0][ARW-1:0]      Arch_Retire_AR;
    logic [N-1:0][PRW-1:0]      Arch_Tnew_in;
    logic [N-1:0]               FL_RetireEN;
    logic [N-1:0][PRW-1:0]      FL_RetireReg;
    logic                       sq_commit_en;
    logic                       halted;
    logic [CNT_W-1:0]           retired_count;
    logic                       recovering;

    modport master (
        output head_valid, head_complete, head_has_dest, head_dest_ar, head_tnew, head_told,
               head_branch, head_pred_taken, head_taken, head_pred_target, head_target,
               head_npc, head_store, head_halt, head_rob_idx, sq_commit_ready,
        input  rob_pop_cnt, rob_flush, rob_flush_idx, BPRecoverEN, redirect_en, redirect_pc,
               Arch_Retire_EN, Arch_Retire_AR, Arch_Tnew_in, FL_RetireEN, FL_RetireReg,
               sq_commit_en, halted, retired_count, recovering
    );

    modport slave (
        input  head_valid, head_complete, head_has_dest, head_dest_ar, head_tnew, head_told,
               head_branch, head_pred_taken, head_taken, head_pred_target, head_target,
               head_npc, head_store, head_halt, head_rob_idx, sq_commit_ready,
        output rob_pop_cnt, rob_flush, rob_flush_idx, BPRecoverEN, redirect_en, redirect_pc,
               Arch_Retire_EN, Arch_Retire_AR, Arch_Tnew_in, FL_RetireEN, FL_RetireReg,
               sq_commit_en, halted, retired_count, recovering
    );
endinterface

// File: rtl/retire_ctrl.sv
// In-order commit stage: retires up to RETIRE_W completed head slots per cycle, handles
// mispredict flush with a counted recovery window, single store commit, and sticky halt.
module retire_ctrl #(
    parameter int N              = 4,
    parameter int RETIRE_W       = N,
    parameter int ARCH_COUNT     = 32,
    parameter int ARW            = $clog2(ARCH_COUNT),
    parameter int PHYS_REGS      = 64,
    parameter int PRW            = $clog2(PHYS_REGS),
    parameter int RECOVER_CYCLES = 2,
    parameter int CNT_W          = 64,
    parameter int ROB_IDX        = 5
) (
    input  logic         clock,
    input  logic         reset,
    retire_ctrl_if.slave rif
);
    localparam int PCW = $clog2(N + 1);
    localparam int RCW = $clog2(RECOVER_CYCLES + 1);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_RECOVER = 2'd1;
    localparam logic [1:0] ST_HALT    = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [RCW-1:0]        rec_cnt_q, rec_cnt_d;
    logic [CNT_W-1:0]      retired_count_q, retired_count_d;
    logic [N-1:0]          arch_en_q, arch_en_d;
    logic [N-1:0][ARW-1:0] arch_ar_q, arch_ar_d;
    logic [N-1:0][PRW-1:0] arch_tnew_q, arch_tnew_d;
    logic [N-1:0]          fl_en_q, fl_en_d;
    logic [N-1:0][PRW-1:0] fl_reg_q, fl_reg_d;

    logic [N-1:0]          mispred;
    logic [N-1:0]          eligible;
    logic [N-1:0]          retire_vec;
    logic [PCW-1:0]        pop_cnt;
    logic                  flush_hit;
    logic [ROB_IDX-1:0]    flush_idx;
    logic [31:0]           flush_pc;
    logic                  halt_hit;
    logic                  store_seen;
    logic                  scan_on;

    // Per-slot qualifiers; slots beyond the retire width are never eligible.
    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        assign mispred[gi] = rif.head_branch[gi] &&
                             ((rif.head_pred_taken[gi] != rif.head_taken[gi]) ||
                              (rif.head_taken[gi] &&
                               (rif.head_pred_target[gi] != rif.head_target[gi])));
        if (gi < RETIRE_W) begin : g_in
            assign eligible[gi] = rif.head_valid[gi] && rif.head_complete[gi];
        end else begin : g_out
            assign eligible[gi] = 1'b0;
        end
    end

    // In-order scan: the first slot that cannot retire, or that flushes/halts, ends it.
    always_comb begin
        retire_vec = '0;
        pop_cnt    = '0;
        flush_hit  = 1'b0;
        flush_idx  = '0;
        flush_pc   = '0;
        halt_hit   = 1'b0;
        store_seen = 1'b0;
        scan_on    = (state_q == ST_RUN);
        for (int w = 0; w < N; w++) begin
            if (scan_on) begin
                if (!eligible[w] ||
                    (rif.head_store[w] && (store_seen || !rif.sq_commit_ready))) begin
                    scan_on = 1'b0;
                end else begin
                    retire_vec[w] = 1'b1;
                    pop_cnt       = pop_cnt + PCW'(1);
                    if (rif.head_store[w]) begin
                        store_seen = 1'b1;
                    end
                    if (mispred[w]) begin
                        flush_hit = 1'b1;
                        flush_idx = rif.head_rob_idx[w];
                        flush_pc  = rif.head_npc[w];
                        scan_on   = 1'b0;
                    end else if (rif.head_halt[w]) begin
                        halt_hit = 1'b1;
                        scan_on  = 1'b0;
                    end
                end
            end
        end
    end

    // Next-cycle map-table and freelist writes; register 0 is never returned to the freelist.
    always_comb begin
        arch_en_d   = '0;
        arch_ar_d   = '0;
        arch_tnew_d = '0;
        fl_en_d     = '0;
        fl_reg_d    = '0;
        for (int w = 0; w < N; w++) begin
            if (retire_vec[w] && rif.head_has_dest[w]) begin
                arch_en_d[w]   = 1'b1;
                arch_ar_d[w]   = rif.head_dest_ar[w];
                arch_tnew_d[w] = rif.head_tnew[w];
                if (rif.head_dest_ar[w] != '0) begin
                    fl_en_d[w]  = 1'b1;
                    fl_reg_d[w] = rif.head_told[w];
                end
            end
        end
    end

    always_comb begin
        retired_count_d = retired_count_q + CNT_W'(pop_cnt);
        state_d         = state_q;
        rec_cnt_d       = rec_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (flush_hit) begin
                    state_d   = ST_RECOVER;
                    rec_cnt_d = RCW'(RECOVER_CYCLES);
                end else if (halt_hit) begin
                    state_d = ST_HALT;
                end
            end
            ST_RECOVER: begin
                if (rec_cnt_q <= RCW'(1)) begin
                    state_d   = ST_RUN;
                    rec_cnt_d = '0;
                end else begin
                    rec_cnt_d = rec_cnt_q - RCW'(1);
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d   = ST_RUN;
                rec_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= ST_RUN;
            rec_cnt_q       <= '0;
            retired_count_q <= '0;
            arch_en_q       <= '0;
            arch_ar_q       <= '0;
            arch_tnew_q     <= '0;
            fl_en_q         <= '0;
            fl_reg_q        <= '0;
        end else begin
            state_q         <= state_d;
            rec_cnt_q       <= rec_cnt_d;
            retired_count_q <= retired_count_d;
            arch_en_q       <= arch_en_d;
            arch_ar_q       <= arch_ar_d;
            arch_tnew_q     <= arch_tnew_d;
            fl_en_q         <= fl_en_d;
            fl_reg_q        <= fl_reg_d;
        end
    end

    assign rif.rob_pop_cnt    = pop_cnt;
    assign rif.rob_flush      = flush_hit;
    assign rif.rob_flush_idx  = flush_idx;
    assign rif.BPRecoverEN    = flush_hit;
    assign rif.redirect_en    = flush_hit;
    assign rif.redirect_pc    = flush_pc;
    assign rif.sq_commit_en   = store_seen;
    assign rif.Arch_Retire_EN = arch_en_q;
    assign rif.Arch_Retire_AR = arch_ar_q;
    assign rif.Arch_Tnew_in   = arch_tnew_q;
    assign rif.FL_RetireEN    = fl_en_q;
    assign rif.FL_RetireReg   = fl_reg_q;
    assign rif.halted         = (state_q == ST_HALT);
    assign rif.recovering     = (state_q == ST_RECOVER);
    assign rif.retired_count  = retired_count_q;
endmodule

// File: tb/tb_retire_ctrl.sv
// Scoreboard bench: two retire_ctrl instances (RETIRE_W=4/CNT_W=64 and RETIRE_W=2/CNT_W=3)
// share one stimulus stream; a reference model queues expected observations per cycle.
module tb_retire_ctrl;
    localparam int N   = 4;
    localparam int ARW = 5;
    localparam int PRW = 6;
    localparam int RIW = 5;
    localparam int PCW = 3;
    localparam int RC  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [N-1:0]           s_valid, s_complete, s_has_dest, s_branch, s_pred_taken, s_taken;
    logic [N-1:0]           s_store, s_halt;
    logic [N-1:0][ARW-1:0]  s_dest_ar;
    logic [N-1:0][PRW-1:0]  s_tnew, s_told;
    logic [N-1:0][31:0]     s_pred_target, s_target, s_npc;
    logic [N-1:0][RIW-1:0]  s_rob_idx;
    logic                   s_ready;

    retire_ctrl_if #(.N(N), .ARW(ARW), .PRW(PRW), .ROB_IDX(RIW), .CNT_W(64)) if_a ();
    retire_ctrl_if #(.N(N), .ARW(ARW), .PRW(PRW), .ROB_IDX(RIW), .CNT_W(3))  if_b ();

    retire_ctrl #(.N(N), .RETIRE_W(4), .ARCH_COUNT(32), .PHYS_REGS(64), .RECOVER_CYCLES(RC),
                  .CNT_W(64), .ROB_IDX(RIW)) dut_a (.clock(clk), .reset(rst_n), .rif(if_a));
    retire_ctrl #(.N(N), .RETIRE_W(2), .ARCH_COUNT(32), .PHYS_REGS(64), .RECOVER_CYCLES(RC),
                  .CNT_W(3), .ROB_IDX(RIW)) dut_b (.clock(clk), .reset(rst_n), .rif(if_b));

    assign if_a.head_valid = s_valid;             assign if_b.head_valid = s_valid;
    assign if_a.head_complete = s_complete;       assign if_b.head_complete = s_complete;
    assign if_a.head_has_dest = s_has_dest;       assign if_b.head_has_dest = s_has_dest;
    assign if_a.head_dest_ar = s_dest_ar;         assign if_b.head_dest_ar = s_dest_ar;
    assign if_a.head_tnew = s_tnew;               assign if_b.head_tnew = s_tnew;
    assign if_a.head_told = s_told;               assign if_b.head_told = s_told;
    assign if_a.head_branch = s_branch;           assign if_b.head_branch = s_branch;
    assign if_a.head_pred_taken = s_pred_taken;   assign if_b.head_pred_taken = s_pred_taken;
    assign if_a.head_taken = s_taken;             assign if_b.head_taken = s_taken;
    assign if_a.head_pred_target = s_pred_target; assign if_b.head_pred_target = s_pred_target;
    assign if_a.head_target = s_target;           assign if_b.head_target = s_target;
    assign if_a.head_npc = s_npc;                 assign if_b.head_npc = s_npc;
    assign if_a.head_store = s_store;             assign if_b.head_store = s_store;
    assign if_a.head_halt = s_halt;               assign if_b.head_halt = s_halt;
    assign if_a.head_rob_idx = s_rob_idx;         assign if_b.head_rob_idx = s_rob_idx;
    assign if_a.sq_commit_ready = s_ready;        assign if_b.sq_commit_ready = s_ready;

    typedef struct packed {
        logic                  chk_reg;
        logic                  chk_comb;
        logic [PCW-1:0]        pop;
        logic                  flush;
        logic [RIW-1:0]        fidx;
        logic                  bpr;
        logic                  redir;
        logic [31:0]           rpc;
        logic                  sqc;
        logic [N-1:0]          aen;
        logic [N-1:0][ARW-1:0] aar;
        logic [N-1:0][PRW-1:0] atn;
        logic [N-1:0]          flen;
        logic [N-1:0][PRW-1:0] flr;
        logic                  halted;
        logic                  recov;
        logic [63:0]           cnt;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: 0=running, 1=recovering, 2=halted
    int                    m_state [2];
    int                    m_left  [2];
    logic [63:0]           m_count [2];
    logic [N-1:0]          m_aen   [2];
    logic [N-1:0][ARW-1:0] m_aar   [2];
    logic [N-1:0][PRW-1:0] m_atn   [2];
    logic [N-1:0]          m_flen  [2];
    logic [N-1:0][PRW-1:0] m_flr   [2];
    bit                    m_known = 1'b0;

    task automatic model_reset(input int i);
        m_state[i] = 0; m_left[i] = 0; m_count[i] = '0;
        m_aen[i] = '0; m_aar[i] = '0; m_atn[i] = '0; m_flen[i] = '0; m_flr[i] = '0;
    endtask

    task automatic model_step(input int i, input int rw, input logic [63:0] mask);
        obs_t         e;
        int           nret;
        bit           sseen, nflush, nhalt;
        logic [N-1:0] ret;
        e = '0; nret = 0; sseen = 0; nflush = 0; nhalt = 0; ret = '0;
        e.chk_reg = m_known;
        e.chk_comb = rst_n && m_known;
        e.aen = m_aen[i]; e.aar = m_aar[i]; e.atn = m_atn[i]; e.flen = m_flen[i]; e.flr = m_flr[i];
        e.halted = (m_state[i] == 2);
        e.recov  = (m_state[i] == 1);
        e.cnt    = m_count[i];
        if (m_state[i] == 0) begin
            for (int w = 0; w < N; w++) begin
                if (!(s_valid[w] && s_complete[w]) || w >= rw) break;
                if (s_store[w]) begin
                    if (sseen || !s_ready) break;
                    sseen = 1; e.sqc = 1'b1;
                end
                ret[w] = 1'b1; nret++;
                if (s_branch[w] && (s_pred_taken[w] != s_taken[w] ||
                    (s_taken[w] && s_pred_target[w] != s_target[w]))) begin
                    e.flush = 1'b1; e.bpr = 1'b1; e.redir = 1'b1;
                    e.fidx = s_rob_idx[w]; e.rpc = s_npc[w]; nflush = 1;
                    break;
                end
                if (s_halt[w]) begin nhalt = 1; break; end
            end
        end
        e.pop = PCW'(nret);
        if (i == 0) q_a.push_back(e); else q_b.push_back(e);
        if (!rst_n) begin
            model_reset(i);
        end else begin
            for (int w = 0; w < N; w++) begin
                m_aen[i][w]  = ret[w] && s_has_dest[w];
                m_aar[i][w]  = m_aen[i][w] ? s_dest_ar[w] : '0;
                m_atn[i][w]  = m_aen[i][w] ? s_tnew[w] : '0;
                m_flen[i][w] = m_aen[i][w] && (s_dest_ar[w] != 0);
                m_flr[i][w]  = m_flen[i][w] ? s_told[w] : '0;
            end
            m_count[i] = (m_count[i] + 64'(nret)) & mask;
            if (m_state[i] == 0) begin
                if (nflush) begin m_state[i] = 1; m_left[i] = RC; end
                else if (nhalt) m_state[i] = 2;
            end else if (m_state[i] == 1) begin
                if (m_left[i] == 1) m_state[i] = 0;
                else m_left[i] = m_left[i] - 1;
            end
        end
    endtask

    task automatic tick();
        model_step(0, 4, 64'hFFFF_FFFF_FFFF_FFFF);
        model_step(1, 2, 64'h7);
        if (!rst_n) m_known = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_window();
        s_valid = '0; s_complete = '0; s_has_dest = '0; s_branch = '0; s_pred_taken = '0;
        s_taken = '0; s_store = '0; s_halt = '0; s_pred_target = '0; s_target = '0;
        for (int w = 0; w < N; w++) begin
            s_dest_ar[w] = ARW'(w + 1);
            s_tnew[w]    = PRW'(8 + w);
            s_told[w]    = PRW'(40 + w);
            s_npc[w]     = 32'h100 + 32'(4 * w);
            s_rob_idx[w] = RIW'(w + 2);
        end
    endtask

    task automatic all_complete();
        clear_window();
        s_valid = '1; s_complete = '1; s_has_dest = '1;
    endtask

    task automatic rand_window();
        int k;
        clear_window();
        for (int w = 0; w < N; w++) begin
            k = int'($urandom_range(0, 99));
            s_valid[w]    = ($urandom_range(0, 9) < 9);
            s_complete[w] = ($urandom_range(0, 9) < 8);
            s_has_dest[w] = ($urandom_range(0, 3) != 0);
            s_dest_ar[w]  = ARW'($urandom_range(0, 31));
            s_tnew[w]     = PRW'($urandom_range(0, 63));
            s_told[w]     = PRW'($urandom_range(0, 63));
            s_npc[w]      = $urandom;
            s_rob_idx[w]  = RIW'($urandom_range(0, 31));
            if (k >= 65 && k < 80) begin
                s_branch[w]      = 1'b1;
                s_pred_taken[w]  = 1'($urandom_range(0, 1));
                s_taken[w]       = ($urandom_range(0, 9) < 7) ? s_pred_taken[w] : ~s_pred_taken[w];
                s_pred_target[w] = 32'($urandom_range(0, 3)) << 2;
                s_target[w]      = ($urandom_range(0, 9) < 7) ? s_pred_target[w] : $urandom;
            end else if (k >= 80 && k < 97) begin
                s_store[w] = 1'b1;
            end else if (k >= 97) begin
                s_halt[w] = 1'b1;
            end
        end
        s_ready = ($urandom_range(0, 9) < 7);
    endtask

    task automatic chk(input string nm, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", nm, inst, $time, act, exp);
        end
    endtask

    task automatic compare(input int inst, input obs_t e, input obs_t a);
        if (e.chk_reg) begin
            chk("arch_en", inst, 64'(a.aen), 64'(e.aen));
            chk("arch_ar", inst, 64'(a.aar), 64'(e.aar));
            chk("arch_tnew", inst, 64'(a.atn), 64'(e.atn));
            chk("fl_en", inst, 64'(a.flen), 64'(e.flen));
            chk("fl_reg", inst, 64'(a.flr), 64'(e.flr));
            chk("halted", inst, 64'(a.halted), 64'(e.halted));
            chk("recovering", inst, 64'(a.recov), 64'(e.recov));
            chk("retired_count", inst, a.cnt, e.cnt);
        end
        if (e.chk_comb) begin
            chk("pop_cnt", inst, 64'(a.pop), 64'(e.pop));
            chk("rob_flush", inst, 64'(a.flush), 64'(e.flush));
            chk("bp_recover", inst, 64'(a.bpr), 64'(e.bpr));
            chk("redirect_en", inst, 64'(a.redir), 64'(e.redir));
            chk("sq_commit_en", inst, 64'(a.sqc), 64'(e.sqc));
            if (e.flush) begin
                chk("flush_idx", inst, 64'(a.fidx), 64'(e.fidx));
                chk("redirect_pc", inst, 64'(a.rpc), 64'(e.rpc));
            end
        end
        $display("obs inst%0d t=%0t pop=%0d flush=%0b sq=%0b aen=%b halted=%0b rec=%0b cnt=%0d",
                 inst, $time, a.pop, a.flush, a.sqc, a.aen, a.halted, a.recov, a.cnt);
    endtask

    function automatic obs_t get_a();
        obs_t o;
        o = '0;
        o.pop = if_a.rob_pop_cnt; o.flush = if_a.rob_flush; o.fidx = if_a.rob_flush_idx;
        o.bpr = if_a.BPRecoverEN; o.redir = if_a.redirect_en; o.rpc = if_a.redirect_pc;
        o.sqc = if_a.sq_commit_en; o.aen = if_a.Arch_Retire_EN; o.aar = if_a.Arch_Retire_AR;
        o.atn = if_a.Arch_Tnew_in; o.flen = if_a.FL_RetireEN; o.flr = if_a.FL_RetireReg;
        o.halted = if_a.halted; o.recov = if_a.recovering; o.cnt = if_a.retired_count;
        return o;
    endfunction

    function automatic obs_t get_b();
        obs_t o;
        o = '0;
        o.pop = if_b.rob_pop_cnt; o.flush = if_b.rob_flush; o.fidx = if_b.rob_flush_idx;
        o.bpr = if_b.BPRecoverEN; o.redir = if_b.redirect_en; o.rpc = if_b.redirect_pc;
        o.sqc = if_b.sq_commit_en; o.aen = if_b.Arch_Retire_EN; o.aar = if_b.Arch_Retire_AR;
        o.atn = if_b.Arch_Tnew_in; o.flen = if_b.FL_RetireEN; o.flr = if_b.FL_RetireReg;
        o.halted = if_b.halted; o.recov = if_b.recovering; o.cnt = 64'(if_b.retired_count);
        return o;
    endfunction

    // Monitor: observes both DUTs mid-cycle and retires queued expectations.
    always @(negedge clk) begin
        if (q_a.size() > 0) compare(0, q_a.pop_front(), get_a());
        if (q_b.size() > 0) compare(1, q_b.pop_front(), get_b());
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hc;
        model_reset(0);
        model_reset(1);
        clear_window();
        s_ready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        tick();
        tick();
        rst_n = 1'b1;

        all_complete(); s_dest_ar[2] = '0; tick();
        all_complete(); s_complete[1] = 1'b0; tick();
        all_complete(); s_branch[1] = 1'b1; s_taken[1] = 1'b1;
        s_npc[1] = 32'h1000; s_rob_idx[1] = RIW'(5); tick();
        all_complete(); tick(); tick(); tick();
        all_complete(); s_store[0] = 1'b1; s_ready = 1'b0; tick();
        s_ready = 1'b1; tick();
        s_store[1] = 1'b1; tick();
        all_complete(); s_halt[2] = 1'b1; tick();
        all_complete(); tick(); tick(); tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; all_complete(); tick(); tick();

        hc = 0;
        for (int c = 0; c < 3000; c++) begin
            rand_window();
            if (m_state[0] == 2 || m_state[1] == 2) hc++; else hc = 0;
            rst_n = !(hc >= 3 || $urandom_range(0, 99) == 0);
            if (!rst_n) hc = 0;
            tick();
        end

        rst_n = 1'b1;
        clear_window();
        for (int k = 0; k < 10 && (q_a.size() > 0 || q_b.size() > 0); k++) @(negedge clk);
        #2;
        n_checks++;
        if (q_a.size() > 0 || q_b.size() > 0) begin
            n_errors++;
            $display("FAIL drain: %0d/%0d expectations left, required 0", q_a.size(), q_b.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/retire_ctrl.md
# retire_ctrl

Second-generation commit stage between the ROB head window and the architectural map table, freelist, store queue and fetch redirect. Retires up to `RETIRE_W` completed instructions per cycle in order. Supports mispredicts in any window slot, one store commit per cycle via handshake, and a sticky halt. A counted recovery FSM gates retirement while the front end and rename state are rebuilt. Map-table and freelist writes are registered; the ROB pop count is combinational so the head advances in the same cycle.

## Interface
- `N`, `` `N ``: ROB head window width, in slots.
- `RETIRE_W`, `N`: maximum retirements per cycle, 1..N.
- `ARCH_COUNT`, 32: number of architectural registers; `ARW = $clog2(ARCH_COUNT)`.
- `PHYS_REGS`, `` `PHYS_REG_SZ_R10K ``: number of physical registers; `PRW = $clog2(PHYS_REGS)`.
- `RECOVER_CYCLES`, 2: cycles retirement is blocked after a flush, ≥1.
- `CNT_W`, 64: width of the retired-instruction counter.
- `clock` in 1: the single clock.
- `reset` in 1: synchronous, active-low. `reset==0` at a `clock` rising edge resets the block.
- Head window, per slot `[N-1:0]`, slot 0 oldest:
  - `head_valid`, `head_complete`, `head_has_dest` in N each.
  - `head_dest_ar` in N×ARW; `head_tnew`, `head_told` in N×PRW.
  - `head_branch`, `head_pred_taken`, `head_taken` in N each.
  - `head_pred_target`, `head_target`, `head_npc` in N×32. `head_npc` is the correct next PC.
  - `head_store`, `head_halt` in N each; `head_rob_idx` in N×ROB_IDX.
- `sq_commit_ready` in 1: the store queue can accept a commit.
- `rob_pop_cnt` out $clog2(N+1): number of slots retired this cycle (combinational).
- `rob_flush` out 1; `rob_flush_idx` out ROB_IDX: flush all entries younger than this index.
- `BPRecoverEN` out 1: copy the precise map into the speculative map.
- `redirect_en` out 1; `redirect_pc` out 32: fetch redirect.
- `Arch_Retire_EN` out N; `Arch_Retire_AR` out N×ARW; `Arch_Tnew_in` out N×PRW: registered map-table updates.
- `FL_RetireEN` out N; `FL_RetireReg` out N×PRW: registered freelist returns.
- `sq_commit_en` out 1: store commit strobe (combinational).
- `halted` out 1: sticky.
- `retired_count` out CNT_W: total instructions retired.
- `recovering` out 1: high while in RECOVER.

## Operation
- FSM has three states: RUN, RECOVER and HALT. Reset enters RUN.
- RUN scans slots 0..N-1 in order. Slot w retires iff all of the following hold:
  - every older slot retired;
  - `head_valid[w] && head_complete[w]`;
  - w < RETIRE_W;
  - if `head_store[w]`: no older store in this cycle and `sq_commit_ready`.
- The first slot that fails these conditions stops the scan.
- Mispredict condition: `head_branch && (pred_taken!=taken || (taken && pred_target!=target))`.
- A retiring mispredicted slot retires itself, including its dest if it has one, and all younger slots are discarded. In that same cycle:
  - `rob_flush=1`, `rob_flush_idx=head_rob_idx[w]`;
  - `BPRecoverEN=1`;
  - `redirect_en=1`, `redirect_pc=head_npc[w]`;
  - next state is RECOVER with the counter loaded to RECOVER_CYCLES.
- A retiring halt slot retires, and all younger slots are discarded. Next state is HALT with `halted=1`.
- Each retired slot with `has_dest` queues an Arch update (EN/AR/Tnew) for the next cycle. It also queues an FL return of Told if `dest_ar!=0`.
- `sq_commit_en=1` in the same cycle a store slot retires.
- `rob_pop_cnt` equals the number of retired slots.
- `retired_count` increases by `rob_pop_cnt` each cycle and wraps modulo 2^CNT_W.
- RECOVER: `rob_pop_cnt=0`, no stores commit, `recovering=1`. The counter decrements each cycle; at 1 the FSM returns to RUN. The head window is ignored.
- HALT: nothing retires and all strobes are 0. Only reset exits this state.

## Timing
- Reset (sync, `reset==0` at an edge) clears:
  - all registered outputs to 0;
  - `halted=0`, `recovering=0`, `retired_count=0`;
  - the FSM to RUN.
- Combinational in the same cycle: `rob_pop_cnt`, `rob_flush*`, `BPRecoverEN`, `redirect_*`, `sq_commit_en`.
- Registered, one cycle after the retire decision: `Arch_*` and `FL_*`. Default 0 whenever no retirement occurred.
- `recovering` is high for exactly RECOVER_CYCLES cycles, starting the cycle after the flush. Retirement resumes on the following cycle.
- A mispredict and a store in the same slot cannot occur.
- If a store is older than the mispredicted branch but `sq_commit_ready=0`, the scan stops at the store and no flush occurs that cycle.
- Reset asserted during RECOVER or HALT takes priority. Any pending registered writes are dropped.
- `retired_count` updates at the edge after retirement.

## Test plan
- N=4, RETIRE_W=4; slots 0-3 complete, all with dests; slot 2 `dest_ar=0` -> `rob_pop_cnt=4`. Next cycle `Arch_Retire_EN=4'b1111` and `FL_RetireEN=4'b1011`. `retired_count`=4.
- Slot 1 incomplete, slots 0, 2, 3 complete -> `rob_pop_cnt=1`; only slot 0 writes; slots 2-3 are not written.
- Slot 1 mispredicted branch (pred_taken=0, taken=1, npc=0x1000), rob_idx 5 -> `pop_cnt=2`, `rob_flush_idx=5`, `redirect_pc=0x1000`, `BPRecoverEN=1`. `recovering` is high for 2 cycles, and `pop_cnt=0` during it even with a complete window.
- Slot 0 store with `sq_commit_ready=0` -> `pop_cnt=0`, `sq_commit_en=0`. Raise ready -> `sq_commit_en=1`. Slots 0 and 1 both stores, ready=1 -> `pop_cnt=1`.
- Slot 2 halt, slots 0-3 complete -> `pop_cnt=3`, `halted=1` thereafter, with no further retirement or strobes. `reset=0` for one edge -> `halted=0`, FSM in RUN, `retired_count=0`.
- RETIRE_W=2, N=4, all slots complete -> `pop_cnt=2`. Preload `retired_count=2^64-1` and retire 2 -> `retired_count` wraps to 1.
